// File: rtl/fir_mac_lane.sv
// fir_mac_lane: one multiply-accumulate lane of the FIR datapath, producing one saturated partial sum per sample strobe.
module fir_mac_lane #(
    parameter int TAPS = 10,
    parameter int DW = 16,
    parameter int AW = 4
) (
    input  logic                 iClk12M,
    input  logic                 iRst,
    input  logic                 iEnSample600k,
    input  logic signed [DW-1:0] iSampleIn,
    input  logic                 iCoeffWrEn,
    input  logic [AW-1:0]        iCoeffAddr,
    input  logic signed [DW-1:0] iCoeffData,
    output logic signed [DW-1:0] oMac,
    output logic                 oMacValid,
    output logic                 oOverrun
);
    localparam int AccW = 2*DW + $clog2(TAPS);
    typedef enum logic [1:0] {Idle, Mac, Done} state_t;
    state_t state;
    logic signed [DW-1:0] rDelay [TAPS];
    logic signed [DW-1:0] rCoeff [TAPS];
    logic signed [AccW-1:0] acc, shifted;
    logic signed [2*DW-1:0] prod;
    logic [AW-1:0] idx;
    logic inRange;
    logic signed [DW-1:0] satVal;
    assign prod = (2*DW)'(rDelay[idx]) * (2*DW)'(rCoeff[idx]);
    assign shifted = acc >>> (DW-1);
    // In range when every bit above the result's sign bit matches it
    assign inRange = &shifted[AccW-1:DW-1] | ~|shifted[AccW-1:DW-1];
    assign satVal = inRange ? shifted[DW-1:0] : {shifted[AccW-1], {(DW-1){~shifted[AccW-1]}}};
    always_ff @(posedge iClk12M or posedge iRst) begin
        if (iRst) begin
            state <= Idle;
            acc <= '0;
            idx <= '0;
            oMac <= '0;
            oMacValid <= 1'b0;
            oOverrun <= 1'b0;
            for (int i = 0; i < TAPS; i++) begin
                rDelay[i] <= '0;
                rCoeff[i] <= '0;
            end
        end else begin
            oMacValid <= 1'b0;
            if (iEnSample600k) begin
                rDelay[0] <= iSampleIn;
                for (int i = 1; i < TAPS; i++) rDelay[i] <= rDelay[i-1];
            end
            if (state == Idle && iCoeffWrEn && {1'b0, iCoeffAddr} < (AW+1)'(TAPS))
                rCoeff[iCoeffAddr] <= iCoeffData;
            // A strobe always restarts the MAC; outside Idle it abandons the running sum
            if (iEnSample600k) begin
                state <= Mac;
                idx <= '0;
                acc <= '0;
                if (state != Idle) oOverrun <= 1'b1;
            end else if (state == Mac) begin
                acc <= acc + AccW'(prod);
                idx <= idx + 1'b1;
                if (idx == AW'(TAPS-1)) state <= Done;
            end else if (state == Done) begin
                oMac <= satVal;
                oMacValid <= 1'b1;
                state <= Idle;
            end
        end
    end
endmodule

// File: tb/tb_fir_mac_lane.sv
// tb_fir_mac_lane: directed stimulus with a queue-based scoreboard checking value and arrival cycle of every result.
module tb_fir_mac_lane;
    logic iClk12M = 1'b0;
    logic iRst = 1'b0;
    logic iEnSample600k = 1'b0;
    logic signed [15:0] iSampleIn = '0;
    logic iCoeffWrEn = 1'b0;
    logic [3:0] iCoeffAddr = '0;
    logic signed [15:0] iCoeffData = '0;
    logic signed [15:0] oMac;
    logic oMacValid, oOverrun;
    typedef struct {
        logic signed [15:0] v;
        int due;
    } exp_t;
    exp_t q[$];
    int cyc = 0;
    int errors = 0;
    int checks = 0;
    logic signed [15:0] negExp [10] = '{32767, 32767, 32767, 32767, -5, -32768, -32768, -32768, -32768, -32768};
    fir_mac_lane dut (
        .iClk12M(iClk12M), .iRst(iRst), .iEnSample600k(iEnSample600k), .iSampleIn(iSampleIn),
        .iCoeffWrEn(iCoeffWrEn), .iCoeffAddr(iCoeffAddr), .iCoeffData(iCoeffData),
        .oMac(oMac), .oMacValid(oMacValid), .oOverrun(oOverrun)
    );
    always #5 iClk12M = ~iClk12M;
    always @(posedge iClk12M) cyc <= cyc + 1;
    task automatic chk(input string n, input logic signed [31:0] got, input logic signed [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", n, got, want);
        end
    endtask
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge iClk12M);
            if (!iRst && oMacValid) begin
                if (q.size() == 0) begin
                    chk("unexpected_valid_cycle", cyc, -1);
                end else begin
                    e = q.pop_front();
                    chk("valid_cycle", cyc, e.due);
                    chk("oMac", oMac, e.v);
                end
            end
        end
    endtask
    task automatic idle(input int n);
        repeat (n) @(negedge iClk12M);
    endtask
    task automatic stb(input logic signed [15:0] s, input bit push, input logic signed [15:0] e);
        @(negedge iClk12M);
        iEnSample600k = 1'b1;
        iSampleIn = s;
        if (push) q.push_back('{e, cyc + 12});
        @(negedge iClk12M);
        iEnSample600k = 1'b0;
    endtask
    task automatic wr(input int a, input logic [15:0] d);
        @(negedge iClk12M);
        iCoeffWrEn = 1'b1;
        iCoeffAddr = a[3:0];
        iCoeffData = d;
        @(negedge iClk12M);
        iCoeffWrEn = 1'b0;
    endtask
    initial begin
        fork
            monitor();
        join_none
        #1 iRst = 1'b1;
        #1;
        chk("reset_oMac", oMac, 0);
        chk("reset_valid", oMacValid, 0);
        chk("reset_overrun", oOverrun, 0);
        idle(2);
        iRst = 1'b0;
        wr(0, 16'h4000);
        stb(1000, 1, 500);
        idle(18);
        stb(-1000, 1, -500);
        idle(18);
        stb(1000, 0, 0);
        idle(4);
        #2 iRst = 1'b1;
        #1;
        chk("midmac_reset_oMac", oMac, 0);
        chk("midmac_reset_valid", oMacValid, 0);
        chk("midmac_reset_overrun", oOverrun, 0);
        idle(1);
        iRst = 1'b0;
        idle(15);
        stb(0, 1, 0);
        idle(18);
        wr(3, 16'h4000);
        stb(100, 1, 0);
        idle(18);
        stb(200, 1, 0);
        idle(18);
        stb(300, 1, 0);
        idle(18);
        stb(400, 1, 50);
        idle(18);
        wr(3, 16'h0000);
        for (int i = 0; i < 10; i++) begin
            stb(16'sh7FFF, 1, 0);
            idle(18);
        end
        for (int i = 0; i < 10; i++) wr(i, 16'h7FFF);
        stb(16'sh7FFF, 1, 32767);
        idle(18);
        for (int i = 0; i < 10; i++) begin
            stb(-32768, 1, negExp[i]);
            idle(18);
        end
        chk("no_overrun_at_20_spacing", oOverrun, 0);
        for (int i = 0; i < 10; i++) wr(i, 16'h0000);
        wr(0, 16'h4000);
        wr(1, 16'h2000);
        stb(1000, 0, 0);
        idle(3);
        stb(2000, 1, 1250);
        idle(18);
        chk("overrun_set", oOverrun, 1);
        wr(12, 16'h7FFF);
        stb(0, 1, 500);
        wr(2, 16'h4000);
        idle(17);
        stb(0, 1, 0);
        idle(18);
        @(negedge iClk12M);
        iEnSample600k = 1'b1;
        iSampleIn = 0;
        iCoeffWrEn = 1'b1;
        iCoeffAddr = 4'd3;
        iCoeffData = 16'sh4000;
        q.push_back('{16'sd1000, cyc + 12});
        @(negedge iClk12M);
        iEnSample600k = 1'b0;
        iCoeffWrEn = 1'b0;
        for (int i = 0; i < 100 && q.size() > 0; i++) @(negedge iClk12M);
        chk("pending_results_left", q.size(), 0);
        idle(3);
        chk("overrun_sticky", oOverrun, 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
